// File: rtl/daq_spi_pkg.sv
// Shared definitions for the DAQ 3-wire SPI engines: FSM encoding, instruction fields, widths.
package daq_spi_pkg;

    localparam int unsigned INSTR_W    = 16;
    localparam int unsigned ADC_DATA_W = 8;
    localparam int unsigned SPI_RW_BIT = 15;
    localparam int unsigned SPI_W_LSB  = 13;
    localparam int unsigned SPI_ADDR_W = 13;
    localparam logic        SPI_READ   = 1'b1;

    typedef logic [2:0] spi_state_t;

    localparam spi_state_t StIdle  = 3'd0;
    localparam spi_state_t StReq   = 3'd1;
    localparam spi_state_t StSetup = 3'd2;
    localparam spi_state_t StInstr = 3'd3;
    localparam spi_state_t StTurn  = 3'd4;
    localparam spi_state_t StData  = 3'd5;
    localparam spi_state_t StHold  = 3'd6;
    localparam spi_state_t StDone  = 3'd7;

    // Single-byte read instruction: R/W flag, W1:W0 = 00, 13-bit register address.
    function automatic logic [INSTR_W-1:0] read_instr(input logic [15:0] addr);
        logic [INSTR_W-1:0] instr;
        instr                       = '0;
        instr[SPI_RW_BIT]           = SPI_READ;
        instr[SPI_W_LSB +: 2]       = 2'b00;
        instr[SPI_ADDR_W-1:0]       = addr[SPI_ADDR_W-1:0];
        return instr;
    endfunction

endpackage

// File: rtl/adc_spi_reader_if.sv
// Control-unit handshake plus shared SPI pin signals of the ADC register-read engine.
interface adc_spi_reader_if;
    import daq_spi_pkg::*;

    logic                  request_read;
    logic [15:0]           adc_address;
    logic [2:0]            adc_select;
    logic                  busy;
    logic                  done;
    logic [ADC_DATA_W-1:0] adc_data_readback;
    logic                  bus_req;
    logic                  bus_grant;
    logic                  sclk;
    logic                  sdio_o;
    logic                  sdio_oe;
    logic                  sdio_i;
    logic [7:0]            adc_csb;

    modport slave (
        input  request_read, adc_address, adc_select, bus_grant, sdio_i,
        output busy, done, adc_data_readback, bus_req, sclk, sdio_o, sdio_oe, adc_csb
    );

    modport master (
        output request_read, adc_address, adc_select, bus_grant, sdio_i,
        input  busy, done, adc_data_readback, bus_req, sclk, sdio_o, sdio_oe, adc_csb
    );

endinterface

// File: rtl/spi_clk_strobe.sv
// Half-period divider: toggles sclk every HALF_DIV cycles while enabled, with rise/fall strobes.
module spi_clk_strobe #(
    parameter int unsigned HALF_DIV = 4
) (
    input  logic sys_clk,
    input  logic reset,
    input  logic enable,
    output logic sclk,
    output logic rise,
    output logic fall
);

    localparam logic [7:0] LastCnt = 8'(HALF_DIV - 1);

    logic [7:0] cnt_q;
    logic       sclk_q;
    logic       edge_now;

    // Strobes mark the cycle whose closing sys_clk edge moves sclk.
    assign edge_now = enable && (cnt_q == LastCnt);
    assign rise     = edge_now && !sclk_q;
    assign fall     = edge_now && sclk_q;
    assign sclk     = sclk_q;

    always_ff @(posedge sys_clk) begin
        if (reset || !enable) begin
            cnt_q  <= '0;
            sclk_q <= 1'b0;
        end else if (edge_now) begin
            cnt_q  <= '0;
            sclk_q <= !sclk_q;
        end else begin
            cnt_q  <= cnt_q + 8'd1;
        end
    end

endmodule

// File: rtl/adc_spi_reader.sv
// ADC register-read engine: arbitrates for the shared 3-wire SPI pins, sends a read
// instruction, turns sdio around and shifts back one data byte.
module adc_spi_reader #(
    parameter int unsigned HALF_DIV = 4
) (
    input logic             sys_clk,
    input logic             reset,
    adc_spi_reader_if.slave bus
);
    import daq_spi_pkg::*;

    localparam logic [7:0] SetupLast = 8'(HALF_DIV);
    localparam logic [7:0] HoldLast  = 8'(HALF_DIV - 1);

    spi_state_t            state_q, state_d;
    logic [7:0]            wait_q;
    logic [4:0]            bit_q;
    logic [INSTR_W-1:0]    instr_q;
    logic [ADC_DATA_W-1:0] shift_q;
    logic [ADC_DATA_W-1:0] readback_q;
    logic [2:0]            sel_q;
    logic                  sclk_en;
    logic                  sclk;
    logic                  rise;
    logic                  fall;
    logic                  csb_active;
    logic                  oe;

    assign sclk_en = (state_q == StInstr) || (state_q == StTurn) || (state_q == StData);

    spi_clk_strobe #(
        .HALF_DIV(HALF_DIV)
    ) u_strobe (
        .sys_clk(sys_clk),
        .reset  (reset),
        .enable (sclk_en),
        .sclk   (sclk),
        .rise   (rise),
        .fall   (fall)
    );

    // SETUP lasts HALF_DIV+1 cycles counting its entry cycle; HOLD lasts HALF_DIV.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (bus.request_read)                  state_d = StReq;
            StReq:   if (bus.bus_grant)                     state_d = StSetup;
            StSetup: if (wait_q == SetupLast)               state_d = StInstr;
            StInstr: if (rise && bit_q == 5'd15)            state_d = StTurn;
            StTurn:  if (fall)                              state_d = StData;
            StData:  if (fall && bit_q == 5'd8)             state_d = StHold;
            StHold:  if (wait_q == HoldLast)                state_d = StDone;
            StDone:                                         state_d = StIdle;
            default:                                        state_d = StIdle;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state_q    <= StIdle;
            wait_q     <= '0;
            bit_q      <= '0;
            instr_q    <= '0;
            shift_q    <= '0;
            sel_q      <= '0;
            readback_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_d != state_q) begin
                wait_q <= '0;
                bit_q  <= '0;
            end else begin
                if (state_q == StSetup || state_q == StHold) wait_q <= wait_q + 8'd1;
                if (rise) bit_q <= bit_q + 5'd1;
            end
            if (state_q == StIdle && bus.request_read) begin
                instr_q <= read_instr(bus.adc_address);
                sel_q   <= bus.adc_select;
            end
            if (state_q == StInstr && fall) instr_q <= {instr_q[INSTR_W-2:0], 1'b0};
            if (state_q == StData && rise) shift_q <= {shift_q[ADC_DATA_W-2:0], bus.sdio_i};
            if (state_q == StHold && state_d == StDone) readback_q <= shift_q;
        end
    end

    assign csb_active = (state_q == StSetup) || (state_q == StInstr) || (state_q == StTurn) ||
                        (state_q == StData) || (state_q == StHold);
    assign oe         = (state_q == StSetup) || (state_q == StInstr) || (state_q == StTurn);

    assign bus.busy              = (state_q != StIdle);
    assign bus.done              = (state_q == StDone);
    assign bus.bus_req           = (state_q == StReq) || csb_active;
    assign bus.adc_csb           = csb_active ? ~(8'd1 << sel_q) : 8'hFF;
    assign bus.sdio_oe           = oe;
    assign bus.sdio_o            = oe ? instr_q[INSTR_W-1] : 1'b0;
    assign bus.sclk              = sclk;
    assign bus.adc_data_readback = readback_q;

endmodule

// File: doc/adc_spi_reader.md
# adc_spi_reader

Register-read engine for the ADC 3-wire SPI bus. `spi_controller` only writes. This block issues the read instruction, turns `sdio` around, and shifts back the 8-bit register value, which the control unit returns on `adc_data_readback`. It shares `sclk`/`sdio`/`adc_csb` with `spi_controller` through a request/grant pair, and the top level muxes the pins on `bus_grant`.

## Interface
Parameters:
- `HALF_DIV`, default 4: `sys_clk` cycles per `sclk` half-period; legal range 2..255.

Ports:
- `sys_clk` in 1: system clock. This block uses one clock only.
- `reset` in 1: synchronous, active-high reset.
- `request_read` in 1: single-cycle read request.
- `adc_address` in 16: register address; bits [12:0] are used, bits [15:13] are ignored.
- `adc_select` in 3: which `adc_csb` bit to drive low.
- `busy` out 1: high from request acceptance until `done`, inclusive.
- `done` out 1: one-cycle pulse marking read completion.
- `adc_data_readback` out 8: the last value read.
- `bus_req` out 1: requests the shared SPI pins.
- `bus_grant` in 1: arbiter grant from the top level.
- `sclk` out 1: SPI clock, idles low.
- `sdio_o` out 1: data driven onto `sdio`.
- `sdio_oe` out 1: output enable for `sdio`.
- `sdio_i` in 1: data sampled from `sdio`.
- `adc_csb` out 8: chip selects, active low.

## Operation
States:
- **IDLE → REQ**: on `request_read` while not `busy`. Latch `adc_address[12:0]` and `adc_select`. Assert `busy` and `bus_req`.
- **REQ → SETUP**: on the first cycle `bus_grant`=1. Drive `adc_csb[adc_select]` low with all other bits high. Set `sdio_oe`=1 and `sdio_o` to instruction bit 15.
- **SETUP → INSTR**: after `HALF_DIV` cycles.
- **INSTR**: shift out the 16-bit instruction MSB first: {1 (read), 2'b00 (one byte), addr[12:0]}.
  - `sdio_o` changes only while `sclk` is low, on the cycle `sclk` falls.
  - The ADC samples on the rising edge.
- **INSTR → TURN**: after the 16th rising edge. On the following falling edge, drop `sdio_oe` to 0.
- **DATA**: 8 rising edges. On each rising-edge cycle, shift `sdio_i` into the shift register MSB first.
- **HOLD**: `sclk` low for `HALF_DIV` cycles, then all `adc_csb` high and `bus_req` low.
- **DONE**: one cycle. Update `adc_data_readback` from the shift register and pulse `done`. Return to IDLE next cycle, with `busy` low.

Rules:
- `request_read` while `busy` is ignored and not queued.
- `bus_grant` is examined only in REQ. Deassertion after entering SETUP is ignored.
- `adc_data_readback` holds its value until the next `done`.
- Bit counter is 5 bits. Rising-edge count is 16 in INSTR and 8 in DATA, and the counter clears on each state entry.

## Timing
- Reset values: `busy`=0, `done`=0, `bus_req`=0, `sclk`=0, `sdio_oe`=0, `sdio_o`=0, `adc_csb`=8'hFF, `adc_data_readback`=8'h00, state IDLE.
- Reset applies on the first `sys_clk` edge with `reset` high, from any state. Mid-transaction, all outputs return to reset values on that edge and no `done` is issued.
- `busy` and `bus_req` rise 1 cycle after the accepted `request_read`.
- `csb` falls 1 cycle after the first `bus_grant`=1 cycle.
- Grant-to-`done` latency is exactly 50·`HALF_DIV`+2 cycles:
  - 1 cycle entering SETUP;
  - `HALF_DIV` setup;
  - 24 `sclk` periods of 2·`HALF_DIV`;
  - `HALF_DIV` hold;
  - 1 cycle for `done`.
- With `HALF_DIV`=4 this is 202 cycles.
- `sdio_oe` falls `HALF_DIV` cycles after the 16th rising edge, so the ADC sees no bus contention.
- Back-to-back: a new `request_read` is accepted in the cycle after `done`.

## Structure
- Shared package `daq_spi_pkg` holds:
  - the state enum;
  - instruction field constants: `SPI_RW_BIT`=15, `SPI_W_LSB`=13, `SPI_ADDR_W`=13, `SPI_READ`=1'b1;
  - `ADC_DATA_W`=8 and `INSTR_W`=16.
- One sub-module, `spi_clk_strobe`: a half-period divider that toggles `sclk` when enabled and emits one-cycle `rise`/`fall` strobes. It is reusable by `spi_controller`.

## Test plan
- Read with `adc_address`=16'h0001, `adc_select`=2, immediate grant, ADC model returning 8'hA5 → `sdio_o` shifts 16'h8001; `adc_csb`=8'hFB during the transfer; `adc_data_readback`=8'hA5 and `done` at 202 cycles after grant.
- `adc_address`=16'hE0FF (bits [15:13] set) → instruction shifted is 16'h80FF.
- `bus_grant` held low for 10 cycles after the request → `adc_csb` stays 8'hFF and `sclk` stays low until grant; latency is then 202 cycles from grant.
- `request_read` pulsed again mid-INSTR → ignored; exactly one `done`.
- `reset` asserted at the 4th DATA rising edge → next cycle `adc_csb`=8'hFF, `sdio_oe`=0, `busy`=0, `adc_data_readback`=8'h00, no `done`.
- Two back-to-back reads returning 8'h3C then 8'hC3 → second accepted the cycle after the first `done`; values update in order; `sdio_oe` is never 1 during DATA.
